// File: rtl/seq_divider_8b_if.sv
// Operation/result handshake bundle for the sequential restoring divider.
// The requester uses the master modport and the divider uses the slave modport.
interface seq_divider_8b_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8b.sv
// Iterative restoring divider: a 2N-bit dividend divided by an N-bit divisor.
// It produces one quotient bit per clock and uses valid/ready on both input and output.
module seq_divider_8b #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_8b_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);

  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_RUN  = 2'd1;
  localparam logic [1:0]    S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST   = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  dvd_q,   dvd_d;
  logic [N-1:0]  dsr_q,   dsr_d;
  logic [N-1:0]  rem_q,   rem_d;
  logic [W-1:0]  quo_q,   quo_d;
  logic          dbz_q,   dbz_d;

  logic [N:0]    trial;
  logic          take;
  logic [N-1:0]  rem_sub;

  // The partial remainder stays below the divisor. Because of that, the N-bit modulo
  // subtract gives the exact difference whenever the trial is at least the divisor.
  assign trial   = {rem_q, dvd_q[W-1]};
  assign take    = (trial >= {1'b0, dsr_q});
  assign rem_sub = trial[N-1:0] - dsr_q;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dvd_d = bus.dividend;
          dsr_d = bus.divisor;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend[N-1:0];
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            quo_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        dvd_d = dvd_q << 1;
        rem_d = take ? rem_sub : trial[N-1:0];
        quo_d = {quo_q[W-2:0], take};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider_8b.md
Name: seq_divider_8b

Overview:
- Iterative restoring divider: the inverse operation of our 4b x 4b -> 8b multipliers.
- Takes a 2N-bit dividend (product width) and an N-bit divisor. Returns a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Used to check or undo multiplier results and as the shared divide unit beside the multiplier arrays.
- Valid/ready handshake on both input and output.

Parameters:
- N, 4, divisor and remainder width. Dividend and quotient are 2N bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation
- dividend  input  2N  unsigned dividend
- divisor  input  N  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- quotient  output  2N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  set with result when divisor == 0

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values:
  - in_ready = 1; out_valid = 0.
  - quotient = 0, remainder = 0, div_by_zero = 0.
  - state = IDLE, step counter = 0.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE), combinational from state only.
- IDLE:
  - Accept occurs on an edge with in_valid & in_ready. Latch dividend into the shift register, divisor into the divisor register; clear the partial remainder and the counter.
  - If divisor == 0: go directly to DONE with quotient = all ones, remainder = dividend[N-1:0], div_by_zero = 1. out_valid is high in the cycle after accept.
  - Otherwise: go to RUN with div_by_zero = 0.
- RUN, one restoring step per edge:
  - trial = {rem[N-1:0], dvd[2N-1]} (N+1 bits); dvd shifts left by 1.
  - If trial >= divisor: rem <= trial - divisor, shift 1 into the quotient LSB.
  - Otherwise: rem <= trial[N-1:0], shift in 0.
  - Invariant: rem < divisor, so N bits always suffice; the N+1-bit compare/subtract is internal only.
  - After the 2N-th step (counter == 2N-1), go to DONE.
- Latency: out_valid rises exactly 2N cycles after the accept edge (8 for N = 4).
- DONE:
  - out_valid = 1; quotient, remainder and div_by_zero are held stable.
  - On out_valid & out_ready, go to IDLE and drop out_valid.
  - Inputs presented while not in IDLE are ignored (in_ready = 0). There is no same-cycle restart.
- Outputs quotient, remainder and div_by_zero are registered. They are undefined-but-stable outside DONE; the bench checks them only when out_valid = 1.
- Reset mid-operation, in RUN or DONE: next state is IDLE, the result is discarded and never presented, and all outputs return to their reset values.
- Simultaneous rst and handshake: rst wins.
- Arithmetic is unsigned only; no overflow is possible since the quotient has 2N bits.
- Result identity, N = 4: dividend == quotient*divisor + remainder and remainder < divisor, for all divisor != 0.
- Target size: about 150 lines of RTL. All arithmetic in this block is written behaviourally.

Test Plan:
- 255 / 15 -> quotient 17, remainder 0, div_by_zero 0; out_valid rises exactly 8 cycles after accept; in_ready is 0 throughout.
- 200 / 7 -> quotient 28, remainder 4. A second op, 5 / 9, presented right after the out handshake -> quotient 0, remainder 5.
- 13 / 0 -> div_by_zero 1, quotient 8'hFF, remainder 4'hD; out_valid is high the cycle after accept.
- Backpressure: 100 / 3 with out_ready held low for 6 cycles after out_valid -> quotient 33, remainder 1 held stable, in_ready 0; a new in_valid is ignored. Raise out_ready -> in_ready returns to 1 next cycle.
- Reset after the 4th RUN step of 250 / 6 -> next cycle IDLE, out_valid 0, in_ready 1. Then 250 / 6 -> quotient 41, remainder 4.
- Exhaustive: all 256 x 16 operand pairs, with random in_valid gaps and random out_ready throttling, against a reference model (div_by_zero path included). Count all results; none may be lost or duplicated.
